// File: rtl/controle_venda_pkg.sv
// controle_venda_pkg: coin codes, credit encodings, controller states, output bundle and default prices
package controle_venda_pkg;
   typedef enum logic [1:0] {M_NENHUMA, M_25, M_50, M_100} moeda_t;
   typedef enum logic [2:0] {OCIOSO, CREDITO, ENTREGA, TROCO, DEVOLVE, ESPERA} estado_t;
   localparam logic [3:0] E0_00 = 4'd0;
   localparam logic [3:0] E0_25 = 4'd1;
   localparam logic [3:0] E0_50 = 4'd2;
   localparam logic [3:0] E0_75 = 4'd3;
   localparam logic [3:0] E1_00 = 4'd4;
   localparam logic [3:0] E1_25 = 4'd5;
   localparam logic [3:0] E1_50 = 4'd6;
   localparam logic [3:0] E1_75 = 4'd7;
   localparam logic [3:0] E2_00 = 4'd8;
   localparam logic [3:0] EX    = 4'd15;
   localparam int PRECO0_PADRAO = 4;
   localparam int PRECO1_PADRAO = 5;
   localparam int PRECO2_PADRAO = 6;
   localparam int PRECO3_PADRAO = 8;
   typedef struct packed {
      logic       libera;
      logic [1:0] produto;
      logic [3:0] troco;
      logic       troco_valido;
      logic       tempo_limite;
      logic       saldo_insuf;
      logic       erro_valor;
   } saidas_t;
   function automatic logic [3:0] preco(input logic [1:0] sel, input logic [3:0] p0, input logic [3:0] p1,
                                        input logic [3:0] p2, input logic [3:0] p3);
      return sel == 2'd0 ? p0 : sel == 2'd1 ? p1 : sel == 2'd2 ? p2 : p3;
   endfunction
endpackage

// File: rtl/controle_venda_temporizador.sv
// temporizador_inatividade: inactivity counter with clear, enable and terminal-count flag at N-1
module temporizador_inatividade #(
   parameter int N = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic fim
);
   localparam int W = $clog2(N);
   logic [W-1:0] cnt;
   assign fim = cnt == W'(N - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !fim) cnt <= cnt + W'(1);
endmodule

// File: rtl/controle_venda.sv
// controle_venda: sale/change controller after the coin accumulator
// VENDAS_CONT_EN defined enables the completed-sale counter; otherwise vendas is tied to zero
module controle_venda
   import controle_venda_pkg::*;
#(
   parameter int PRECO0         = PRECO0_PADRAO,
   parameter int PRECO1         = PRECO1_PADRAO,
   parameter int PRECO2         = PRECO2_PADRAO,
   parameter int PRECO3         = PRECO3_PADRAO,
   parameter int TIMEOUT_CICLOS = 1000,
   parameter int LIBERA_CICLOS  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] valorAcumulado,
   input  logic [1:0] selecao,
   input  logic       confirma,
   input  logic       cancela,
   output logic       tempoLimite,
   output logic       libera,
   output logic [1:0] produto,
   output logic [3:0] troco,
   output logic       trocoValido,
   output logic       saldoInsuf,
   output logic       erroValor,
   output logic [7:0] vendas
);
   localparam int LW = $clog2(LIBERA_CICLOS + 1);
   estado_t estado, prox;
   saidas_t d, q;
   logic [3:0] anterior, preco_sel;
   logic [LW-1:0] cnt_lib;
   logic novo, fim, suficiente, insuf;
   assign preco_sel  = preco(selecao, 4'(PRECO0), 4'(PRECO1), 4'(PRECO2), 4'(PRECO3));
   assign novo       = valorAcumulado != anterior;
   assign suficiente = valorAcumulado >= preco_sel;
   assign insuf      = estado == CREDITO && valorAcumulado != EX && !cancela && confirma && !suficiente;
   temporizador_inatividade #(.N(TIMEOUT_CICLOS)) u_temporizador (
      .clk    (clk),
      .reset  (reset),
      .clear  (estado != CREDITO || novo || insuf),
      .enable (estado == CREDITO),
      .fim    (fim)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         estado   <= OCIOSO;
         anterior <= '0;
         cnt_lib  <= '0;
         q        <= '0;
      end else begin
         estado   <= prox;
         anterior <= valorAcumulado;
         cnt_lib  <= estado == ENTREGA ? cnt_lib + LW'(1) : '0;
         q        <= d;
      end
   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  prox = valorAcumulado != E0_00 ? CREDITO : OCIOSO;
         CREDITO: prox = (valorAcumulado == EX || cancela) ? DEVOLVE :
                         confirma ? (suficiente ? ENTREGA : CREDITO) :
                         fim ? DEVOLVE :
                         valorAcumulado == E0_00 ? OCIOSO : CREDITO;
         ENTREGA: prox = cnt_lib == LW'(LIBERA_CICLOS - 1) ? TROCO : ENTREGA;
         TROCO:   prox = ESPERA;
         DEVOLVE: prox = ESPERA;
         ESPERA:  prox = valorAcumulado == E0_00 ? OCIOSO : ESPERA;
         default: prox = OCIOSO;
      endcase
   end
   // change is fixed at the CREDITO decision and held through ENTREGA until the TROCO strobe
   always_comb begin
      d.libera       = prox == ENTREGA;
      d.produto      = prox != ENTREGA ? 2'd0 : estado == CREDITO ? selecao : q.produto;
      d.troco        = estado == CREDITO ? (prox == DEVOLVE ? (valorAcumulado == EX ? 4'd0 : valorAcumulado) :
                                            prox == ENTREGA ? valorAcumulado - preco_sel : 4'd0) :
                       estado == ENTREGA ? q.troco : 4'd0;
      d.troco_valido = prox == TROCO || prox == DEVOLVE;
      d.tempo_limite = prox == TROCO || prox == DEVOLVE;
      d.saldo_insuf  = insuf;
      d.erro_valor   = estado == CREDITO && valorAcumulado == EX;
   end
   assign libera      = q.libera;
   assign produto     = q.produto;
   assign troco       = q.troco;
   assign trocoValido = q.troco_valido;
   assign tempoLimite = q.tempo_limite;
   assign saldoInsuf  = q.saldo_insuf;
   assign erroValor   = q.erro_valor;
`ifdef VENDAS_CONT_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) vendas <= '0;
      else if (estado == ENTREGA && prox == TROCO) vendas <= vendas + 8'd1;
`else
   assign vendas = 8'd0;
`endif
endmodule
